// File: rtl/ex_stage_pm_if.sv
// ex_stage_pm_if: bundles the ID/EX operands and controls, the MEM/WB forwarding path
// and the registered EX/MEM outputs of the execute stage.
// Flow control: stall is the only backpressure signal. While stall=1 the upstream
// stages hold the instruction on id_* unchanged. The stage consumes it in the first
// cycle with stall=0. flush=1 squashes whatever is in EX, regardless of stall.
// dbg_state mirrors the mul/div FSM: 0 idle, 1 busy, 2 done (always 0 when the
// mul/div unit is not built).
`timescale 1ns/1ps
interface ex_stage_pm_if #(
    parameter int WIDTH = 32,
    parameter int RW    = 5
);
    logic [WIDTH-1:0] id_rs_data;
    logic [WIDTH-1:0] id_rt_data;
    logic [WIDTH-1:0] id_imm;
    logic [3:0]       id_ex_ctrl;
    logic [RW-1:0]    id_rs;
    logic [RW-1:0]    id_rt;
    logic [RW-1:0]    id_rd;
    logic [1:0]       id_wb;
    logic             id_mem_read;
    logic             id_mem_write;
    logic [WIDTH-1:0] wb_data;
    logic [RW-1:0]    wb_rd;
    logic             wb_reg_write;
    logic             flush;
    logic [1:0]       mem_wb;
    logic             mem_read;
    logic             mem_write;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [RW-1:0]    mem_rd;
    logic             zero;
    logic             stall;
    logic [1:0]       dbg_state;

    modport master (
        output id_rs_data, id_rt_data, id_imm, id_ex_ctrl, id_rs, id_rt, id_rd,
               id_wb, id_mem_read, id_mem_write, wb_data, wb_rd, wb_reg_write, flush,
        input  mem_wb, mem_read, mem_write, mem_addr, mem_wdata, mem_rd, zero,
               stall, dbg_state
    );

    modport slave (
        input  id_rs_data, id_rt_data, id_imm, id_ex_ctrl, id_rs, id_rt, id_rd,
               id_wb, id_mem_read, id_mem_write, wb_data, wb_rd, wb_reg_write, flush,
        output mem_wb, mem_read, mem_write, mem_addr, mem_wdata, mem_rd, zero,
               stall, dbg_state
    );
endinterface

// File: rtl/ex_stage_pm.sv
// ex_stage_pm: execute stage with operand forwarding, ALU, optional iterative
// multiply/divide unit (compiled in when EX_MULDIV_EN is defined) and the EX/MEM
// pipeline register. Without EX_MULDIV_EN, MULT/DIVU decode as unknown funct.
`timescale 1ns/1ps
module ex_stage_pm #(
    parameter int WIDTH = 32,
    parameter int RW    = 5
) (
    input logic         clk,
    input logic         rst,
    ex_stage_pm_if.slave bus
);
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    logic [5:0]       w_funct;
    logic [WIDTH-1:0] w_fwd_a;
    logic [WIDTH-1:0] w_fwd_b;
    logic [WIDTH-1:0] w_op_b;
    logic [WIDTH-1:0] w_alu_res;
    logic [WIDTH-1:0] w_result;
    logic             w_stall;

    logic [1:0]       r_mem_wb;
    logic             r_mem_read;
    logic             r_mem_write;
    logic [WIDTH-1:0] r_mem_addr;
    logic [WIDTH-1:0] r_mem_wdata;
    logic [RW-1:0]    r_mem_rd;
    logic             r_zero;

    assign w_funct = bus.id_imm[5:0];
    assign w_op_b  = bus.id_ex_ctrl[0] ? bus.id_imm : w_fwd_b;

    // Forwarding: the younger EX/MEM result wins over MEM/WB; register 0 never forwards.
    always_comb begin
        w_fwd_a = bus.id_rs_data;
        w_fwd_b = bus.id_rt_data;
        if (r_mem_wb[1] && (r_mem_rd != '0) && (r_mem_rd == bus.id_rs))
            w_fwd_a = r_mem_addr;
        else if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == bus.id_rs))
            w_fwd_a = bus.wb_data;
        if (r_mem_wb[1] && (r_mem_rd != '0) && (r_mem_rd == bus.id_rt))
            w_fwd_b = r_mem_addr;
        else if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == bus.id_rt))
            w_fwd_b = bus.wb_data;
    end

    // Single-cycle ALU; MULT/DIVU and unknown funct codes yield 0 here.
    always_comb begin
        w_alu_res = '0;
        case (bus.id_ex_ctrl[2:1])
            2'b00: w_alu_res = w_fwd_a + w_op_b;
            2'b01: w_alu_res = w_fwd_a - w_op_b;
            2'b11: w_alu_res = WIDTH'($signed(w_fwd_a) < $signed(w_op_b));
            default: begin
                case (w_funct)
                    F_ADD:   w_alu_res = w_fwd_a + w_op_b;
                    F_SUB:   w_alu_res = w_fwd_a - w_op_b;
                    F_AND:   w_alu_res = w_fwd_a & w_op_b;
                    F_OR:    w_alu_res = w_fwd_a | w_op_b;
                    F_SLT:   w_alu_res = WIDTH'($signed(w_fwd_a) < $signed(w_op_b));
                    default: w_alu_res = '0;
                endcase
            end
        endcase
    end

`ifdef EX_MULDIV_EN
    localparam logic [5:0] F_MULT = 6'h18;
    localparam logic [5:0] F_DIVU = 6'h1A;
    localparam int         CW     = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_div;
    // Multiply: r_acc = product, r_x = shifted multiplicand, r_y = multiplier.
    // Divide:   r_acc = remainder, r_x = divisor, r_y = dividend shifting into quotient.
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic             w_is_muldiv;
    logic             w_start;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;

    assign w_is_muldiv = (bus.id_ex_ctrl[2:1] == 2'b10) &&
                         ((w_funct == F_MULT) || (w_funct == F_DIVU));
    // DONE is not IDLE, so the instruction still held in EX cannot restart the unit.
    assign w_start  = (r_state == S_IDLE) && w_is_muldiv && !bus.flush;
    assign w_stall  = rst && !bus.flush && (w_start || (r_state == S_BUSY));
    assign w_rem_sh = {r_acc, r_y[WIDTH-1]};
    // A zero divisor never borrows, so the quotient fills with ones.
    assign w_diff   = w_rem_sh - {1'b0, r_x};
    assign w_result = (r_state == S_DONE) ? (r_div ? r_y : r_acc) : w_alu_res;
    assign bus.dbg_state = r_state;

    // Mul/div sequencer: latch operands at start, one shift-add / restoring step per BUSY cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_acc   <= '0;
            r_x     <= '0;
            r_y     <= '0;
        end else if (bus.flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_BUSY;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_div   <= (w_funct == F_DIVU);
                        if (w_funct == F_DIVU) begin
                            r_x <= w_op_b;
                            r_y <= w_fwd_a;
                        end else begin
                            r_x <= w_fwd_a;
                            r_y <= w_op_b;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_div) begin
                        if (!w_diff[WIDTH]) begin
                            r_acc <= w_diff[WIDTH-1:0];
                            r_y   <= {r_y[WIDTH-2:0], 1'b1};
                        end else begin
                            r_acc <= w_rem_sh[WIDTH-1:0];
                            r_y   <= {r_y[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        if (r_y[0])
                            r_acc <= r_acc + r_x;
                        r_x <= r_x << 1;
                        r_y <= r_y >> 1;
                    end
                    if (r_cnt == CW'(WIDTH - 1))
                        r_state <= S_DONE;
                    else
                        r_cnt <= r_cnt + 1'b1;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
`else
    assign w_stall       = 1'b0;
    assign w_result      = w_alu_res;
    assign bus.dbg_state = 2'b00;
`endif

    // EX/MEM register: bubble on flush or stall (data fields held), otherwise capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_wb    <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_rd    <= '0;
            r_zero      <= 1'b0;
        end else if (bus.flush || w_stall) begin
            r_mem_wb    <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            r_mem_wb    <= bus.id_wb;
            r_mem_read  <= bus.id_mem_read;
            r_mem_write <= bus.id_mem_write;
            r_mem_addr  <= w_result;
            r_mem_wdata <= w_fwd_b;
            r_mem_rd    <= bus.id_ex_ctrl[3] ? bus.id_rd : bus.id_rt;
            r_zero      <= (w_result == '0);
        end
    end

    assign bus.mem_wb    = r_mem_wb;
    assign bus.mem_read  = r_mem_read;
    assign bus.mem_write = r_mem_write;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_rd    = r_mem_rd;
    assign bus.zero      = r_zero;
    assign bus.stall     = w_stall;
endmodule

// File: tb/tb_ex_stage_pm.sv
// tb_ex_stage_pm: directed plus randomized checks of ex_stage_pm against a
// behavioural model (forwarding rules, plain arithmetic for ALU/MULT/DIVU).
// Mul/div checks are compiled when EX_MULDIV_EN is defined; otherwise MULT/DIVU
// are expected to behave as unknown funct codes.
`timescale 1ns/1ps
module tb_ex_stage_pm;
    localparam int W  = 32;
    localparam int RW = 5;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    ex_stage_pm_if #(.WIDTH(W), .RW(RW)) bus ();
    ex_stage_pm #(.WIDTH(W), .RW(RW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // clock / timeout
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    // model of the EX/MEM register contents
    logic [1:0]    m_wb;
    logic          m_read, m_write, m_zero;
    logic [W-1:0]  m_addr, m_wdata;
    logic [RW-1:0] m_rd;
    logic [W-1:0]  exp_q[$];

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] fwd(input logic [RW-1:0] idx, input logic [W-1:0] rf);
        if (m_wb[1] && idx != '0 && m_rd == idx) return m_addr;
        if (bus.wb_reg_write && bus.wb_rd != '0 && bus.wb_rd == idx) return bus.wb_data;
        return rf;
    endfunction

    function automatic logic [W-1:0] ref_alu(input logic [1:0] op, input logic [5:0] funct,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] prod;
        case (op)
            2'b00: return a + b;
            2'b01: return a - b;
            2'b11: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            default: begin
                case (funct)
                    6'h20: return a + b;
                    6'h22: return a - b;
                    6'h24: return a & b;
                    6'h25: return a | b;
                    6'h2A: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
`ifdef EX_MULDIV_EN
                    6'h18: begin
                        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                        return prod[W-1:0];
                    end
                    6'h1A: return (b == '0) ? {W{1'b1}} : a / b;
`endif
                    default: return '0;
                endcase
            end
        endcase
    endfunction

    // driver tasks
    task automatic drive(input logic [W-1:0] rs_d, input logic [W-1:0] rt_d,
                         input logic [W-1:0] imm, input logic [3:0] ctrl,
                         input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                         input logic [RW-1:0] rd, input logic [1:0] wb,
                         input logic mr, input logic mw);
        bus.id_rs_data   = rs_d;
        bus.id_rt_data   = rt_d;
        bus.id_imm       = imm;
        bus.id_ex_ctrl   = ctrl;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_rd        = rd;
        bus.id_wb        = wb;
        bus.id_mem_read  = mr;
        bus.id_mem_write = mw;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".addr"}, bus.mem_addr, exp_q.pop_front());
        chk({tag, ".wdata"}, bus.mem_wdata, m_wdata);
        chk({tag, ".rd"}, W'(bus.mem_rd), W'(m_rd));
        chk({tag, ".wb"}, W'(bus.mem_wb), W'(m_wb));
        chk({tag, ".read"}, W'(bus.mem_read), W'(m_read));
        chk({tag, ".write"}, W'(bus.mem_write), W'(m_write));
        chk({tag, ".zero"}, W'(bus.zero), W'(m_zero));
    endtask

    // One single-cycle instruction (or a flushed one); called just after a rising edge.
    task automatic issue(input logic [W-1:0] rs_d, input logic [W-1:0] rt_d,
                         input logic [W-1:0] imm, input logic [3:0] ctrl,
                         input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                         input logic [RW-1:0] rd, input logic [1:0] wb,
                         input logic mr, input logic mw, input logic fl, input string tag);
        logic [W-1:0] a, bt, b, res;
        drive(rs_d, rt_d, imm, ctrl, rs, rt, rd, wb, mr, mw);
        bus.flush = fl;
        a   = fwd(rs, rs_d);
        bt  = fwd(rt, rt_d);
        b   = ctrl[0] ? imm : bt;
        res = ref_alu(ctrl[2:1], imm[5:0], a, b);
        #1;
        chk({tag, ".stall"}, W'(bus.stall), W'(0));
        if (!fl) begin
            m_wb = wb; m_read = mr; m_write = mw;
            m_addr = res; m_wdata = bt; m_rd = ctrl[3] ? rd : rt; m_zero = (res == '0);
        end else begin
            m_wb = 2'b00; m_read = 1'b0; m_write = 1'b0;
        end
        exp_q.push_back(m_addr);
        @(posedge clk); #1;
        check_outputs(tag);
    endtask

`ifdef EX_MULDIV_EN
    // One MULT/DIVU: count stall cycles (bounded), then check the captured result.
    task automatic run_muldiv(input logic [5:0] funct, input logic [W-1:0] rs_d,
                              input logic [W-1:0] rt_d, input logic [RW-1:0] rs,
                              input logic [RW-1:0] rt, input logic disturb, input string tag);
        logic [W-1:0] a, bt, res;
        int n_stall;
        drive(rs_d, rt_d, {26'h0, funct}, 4'b1100, rs, rt, 5'd3, 2'b10, 1'b0, 1'b0);
        bus.flush = 1'b0;
        a   = fwd(rs, rs_d);
        bt  = fwd(rt, rt_d);
        res = ref_alu(2'b10, funct, a, bt);
        n_stall = 0;
        #1;
        while (bus.stall === 1'b1 && n_stall < 200) begin
            n_stall++;
            @(posedge clk); #1;
            m_wb = 2'b00; m_read = 1'b0; m_write = 1'b0;
            chk({tag, ".bubble"}, W'(bus.mem_wb), W'(m_wb));
            if (disturb) bus.wb_data = $urandom();
        end
        chk({tag, ".stall_cycles"}, W'(n_stall), W'(W + 1));
        m_wb = 2'b10; m_read = 1'b0; m_write = 1'b0;
        m_wdata = fwd(rt, rt_d);
        m_addr = res; m_rd = 5'd3; m_zero = (res == '0);
        exp_q.push_back(res);
        @(posedge clk); #1;
        check_outputs(tag);
    endtask
`endif

    initial begin
        logic [W-1:0] r, rs_d, rt_d;
        logic [5:0]   funct;
        logic [1:0]   op;
        logic [3:0]   ctrl;

        // reset block: a MULT sits on the inputs, stall must stay low in reset
        rst = 1'b0;
        bus.flush = 1'b0; bus.wb_reg_write = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
        drive(32'd3, 32'd5, 32'h18, 4'b0100, 5'd1, 5'd2, 5'd3, 2'b10, 1'b1, 1'b1);
        #12;
        chk("reset.addr", bus.mem_addr, '0);
        chk("reset.wdata", bus.mem_wdata, '0);
        chk("reset.rd", W'(bus.mem_rd), '0);
        chk("reset.wb", W'(bus.mem_wb), '0);
        chk("reset.read", W'(bus.mem_read), '0);
        chk("reset.write", W'(bus.mem_write), '0);
        chk("reset.zero", W'(bus.zero), '0);
        chk("reset.stall", W'(bus.stall), '0);
        chk("reset.state", W'(bus.dbg_state), '0);
        drive('0, '0, '0, 4'b0000, '0, '0, '0, 2'b00, 1'b0, 1'b0);
        m_wb = '0; m_read = 0; m_write = 0; m_addr = '0; m_wdata = '0; m_rd = '0; m_zero = 0;
        rst = 1'b1;

        // basic R-type add
        issue(32'd7, 32'd9, 32'h20, 4'b1100, 5'd5, 5'd6, 5'd3, 2'b10, 0, 0, 0, "tp_add");
        chk("tp_add.const_addr", bus.mem_addr, 32'd16);
        chk("tp_add.const_rd", W'(bus.mem_rd), 32'd3);

        // forwarding priority EX/MEM over MEM/WB
        issue('0, '0, 32'd100, 4'b0001, 5'd0, 5'd4, 5'd0, 2'b10, 0, 0, 0, "fw_seed");
        bus.wb_reg_write = 1'b1; bus.wb_rd = 5'd4; bus.wb_data = 32'd50;
        issue(32'd7, '0, 32'd1, 4'b0011, 5'd4, 5'd5, 5'd0, 2'b10, 0, 0, 0, "fw_exmem");
        chk("fw_exmem.const", bus.mem_addr, 32'd99);
        issue(32'd7, '0, 32'd1, 4'b0011, 5'd4, 5'd6, 5'd0, 2'b10, 0, 0, 0, "fw_memwb");
        chk("fw_memwb.const", bus.mem_addr, 32'd49);
        issue('0, '0, 32'd100, 4'b0001, 5'd0, 5'd0, 5'd0, 2'b10, 0, 0, 0, "fw0_seed");
        bus.wb_rd = 5'd0;
        issue(32'd7, '0, 32'd1, 4'b0011, 5'd0, 5'd7, 5'd0, 2'b10, 0, 0, 0, "fw_idx0");
        chk("fw_idx0.const", bus.mem_addr, 32'd6);
        issue(32'h1000, 32'hDEAD, 32'd4, 4'b0001, 5'd0, 5'd7, 5'd0, 2'b00, 0, 1, 0, "fw_store");
        chk("fw_store.const_wdata", bus.mem_wdata, 32'd6);
        bus.wb_reg_write = 1'b0;

        // zero flag, signed slt, flush bubble
        issue(32'd9, 32'd9, 32'h22, 4'b1100, 5'd1, 5'd2, 5'd3, 2'b10, 0, 0, 0, "zero");
        chk("zero.const", W'(bus.zero), 32'd1);
        issue(32'hFFFF_FFFF, 32'd1, 32'h0, 4'b0110, 5'd1, 5'd2, 5'd3, 2'b10, 0, 0, 0, "slt");
        chk("slt.const", bus.mem_addr, 32'd1);
        issue(32'd1, 32'd2, 32'h20, 4'b1100, 5'd1, 5'd2, 5'd3, 2'b10, 1, 1, 1, "flush");
        chk("flush.const_wb", W'(bus.mem_wb), 32'd0);

        // randomized single-cycle traffic
        for (int i = 0; i < 80; i++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: funct = 6'h20;
                1: funct = 6'h22;
                2: funct = 6'h24;
                3: funct = 6'h25;
                4: funct = 6'h2A;
                5: funct = 6'h18;
                6: funct = 6'h1A;
                default: funct = 6'($urandom_range(0, 63));
            endcase
`ifdef EX_MULDIV_EN
            if (funct == 6'h18 || funct == 6'h1A) funct = 6'h25;
`endif
            r = $urandom();
            rt_d = $urandom();
            rs_d = ($urandom_range(0, 3) == 0) ? rt_d : $urandom();
            ctrl = {1'($urandom_range(0, 1)), op, 1'($urandom_range(0, 1))};
            bus.wb_reg_write = 1'($urandom_range(0, 1));
            bus.wb_rd = RW'($urandom_range(0, 7));
            bus.wb_data = $urandom();
            issue(rs_d, rt_d, {r[W-1:6], funct}, ctrl, RW'($urandom_range(0, 7)),
                  RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), "rand");
        end
        bus.wb_reg_write = 1'b0;

`ifdef EX_MULDIV_EN
        issue('0, '0, '0, 4'b0000, 5'd0, 5'd0, 5'd0, 2'b00, 0, 0, 0, "nop");
        run_muldiv(6'h18, 32'h0001_0003, 32'd5, 5'd1, 5'd2, 0, "mult");
        chk("mult.const", bus.mem_addr, 32'h0005_000F);
        run_muldiv(6'h18, $urandom(), $urandom(), 5'd1, 5'd2, 0, "mult_b2b");
        issue(32'd2, 32'd3, 32'h20, 4'b1100, 5'd1, 5'd2, 5'd4, 2'b10, 0, 0, 0, "after_mult");
        run_muldiv(6'h1A, 32'd100, 32'd7, 5'd1, 5'd2, 0, "divu");
        chk("divu.const", bus.mem_addr, 32'd14);
        run_muldiv(6'h1A, 32'd5, 32'd0, 5'd1, 5'd2, 0, "divu0");
        chk("divu0.const", bus.mem_addr, 32'hFFFF_FFFF);
        bus.wb_reg_write = 1'b1; bus.wb_rd = 5'd9; bus.wb_data = 32'd1000;
        run_muldiv(6'h1A, 32'd1, 32'd7, 5'd9, 5'd10, 1, "divu_fwd");
        chk("divu_fwd.const", bus.mem_addr, 32'd142);
        bus.wb_reg_write = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rt_d = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 1 << (i * 5)));
            run_muldiv(($urandom_range(0, 1) == 1) ? 6'h18 : 6'h1A, $urandom(), rt_d,
                       5'd1, 5'd2, 0, "muldiv_rand");
        end

        // flush in the tenth BUSY cycle
        drive(32'd1000, 32'd3, 32'h1A, 4'b1100, 5'd1, 5'd2, 5'd3, 2'b10, 0, 0);
        #1;
        chk("fl.start_stall", W'(bus.stall), 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
        end
        m_wb = 2'b00; m_read = 1'b0; m_write = 1'b0;
        chk("fl.busy_stall", W'(bus.stall), 32'd1);
        bus.flush = 1'b1;
        #1;
        chk("fl.stall_drop", W'(bus.stall), 32'd0);
        exp_q.push_back(m_addr);
        @(posedge clk); #1;
        check_outputs("fl");
        chk("fl.state_idle", W'(bus.dbg_state), 32'd0);
        issue(32'd2, 32'd3, 32'h20, 4'b1100, 5'd1, 5'd2, 5'd4, 2'b10, 0, 0, 0, "after_fl");

        // asynchronous reset mid-DIVU
        issue(32'd3, 32'd4, 32'h20, 4'b1100, 5'd1, 5'd2, 5'd5, 2'b10, 0, 0, 0, "pre_rst");
        drive(32'd1000, 32'd3, 32'h1A, 4'b1100, 5'd1, 5'd2, 5'd3, 2'b10, 0, 0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid.addr", bus.mem_addr, '0);
        chk("rst_mid.wdata", bus.mem_wdata, '0);
        chk("rst_mid.rd", W'(bus.mem_rd), '0);
        chk("rst_mid.zero", W'(bus.zero), '0);
        chk("rst_mid.stall", W'(bus.stall), '0);
        chk("rst_mid.state", W'(bus.dbg_state), '0);
        drive('0, '0, '0, 4'b0000, '0, '0, '0, 2'b00, 1'b0, 1'b0);
        m_wb = '0; m_read = 0; m_write = 0; m_addr = '0; m_wdata = '0; m_rd = '0; m_zero = 0;
        rst = 1'b1;
        issue(32'd8, 32'd2, 32'h22, 4'b1100, 5'd1, 5'd2, 5'd6, 2'b10, 0, 0, 0, "after_rst");
`else
        issue(32'd3, 32'd5, 32'h18, 4'b1100, 5'd1, 5'd2, 5'd3, 2'b10, 0, 0, 0, "mult_off");
        chk("mult_off.const", bus.mem_addr, 32'd0);
        issue(32'd100, 32'd7, 32'h1A, 4'b1100, 5'd1, 5'd2, 5'd3, 2'b10, 0, 0, 0, "divu_off");
        chk("divu_off.const", bus.mem_addr, 32'd0);
        issue(32'd2, 32'd3, 32'h20, 4'b1100, 5'd1, 5'd2, 5'd4, 2'b10, 0, 0, 0, "after_off");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
